// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction widths and the
// instruction length rule used by both fetch and decode.
package cpu_pkg;

    localparam int HALFWORD_WIDTH = 16;
    localparam int INST_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HW0,
        WAIT_HW1,
        DONE
    } fetch_state_t;

    // A set opcode MSB in the first halfword marks a 32-bit instruction.
    function automatic logic is_long_inst(input logic [HALFWORD_WIDTH-1:0] halfword);
        return halfword[HALFWORD_WIDTH-1];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads a 16- or 32-bit instruction from synchronous
// instruction memory on fetch_start, holds it, and advances the PC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      rst_sync,
    input  logic                      fetch_start,
    input  logic                      pc_load,
    input  logic [ADDR_WIDTH-1:0]     pc_load_addr,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    output logic                      imem_rd_en,
    input  logic [HALFWORD_WIDTH-1:0] imem_rd_data,
    output logic [INST_WIDTH-1:0]     inst,
    output logic [ADDR_WIDTH-1:0]     inst_addr,
    output logic                      inst_is_long,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic                      fetch_complete
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    fetch_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]     pc_q;
    logic [INST_WIDTH-1:0]     inst_q;
    logic [ADDR_WIDTH-1:0]     inst_addr_q;
    logic                      inst_is_long_q;
    logic                      fetch_complete_q;
    logic                      hw0_long;

    always_comb begin
        hw0_long   = is_long_inst(imem_rd_data);
        state_d    = state_q;
        imem_rd_en = 1'b0;
        imem_addr  = pc_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    imem_addr = pc_load_addr;
                end
                if (fetch_start) begin
                    imem_rd_en = 1'b1;
                    state_d    = WAIT_HW0;
                end
            end
            WAIT_HW0: begin
                if (hw0_long) begin
                    imem_rd_en = 1'b1;
                    state_d    = WAIT_HW1;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_HW1: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            inst_q           <= '0;
            inst_addr_q      <= '0;
            inst_is_long_q   <= 1'b0;
            fetch_complete_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            fetch_complete_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        pc_q <= imem_addr + PC_ONE;
                    end else if (pc_load) begin
                        pc_q <= pc_load_addr;
                    end
                end
                WAIT_HW0: begin
                    // The fetch address is recovered as pc-1 here so inst_addr
                    // changes together with inst and stays stable until this edge.
                    inst_q[HALFWORD_WIDTH-1:0] <= imem_rd_data;
                    inst_addr_q                <= pc_q - PC_ONE;
                    inst_is_long_q             <= hw0_long;
                    if (hw0_long) begin
                        pc_q <= pc_q + PC_ONE;
                    end else begin
                        inst_q[INST_WIDTH-1:HALFWORD_WIDTH] <= '0;
                    end
                end
                WAIT_HW1: inst_q[INST_WIDTH-1:HALFWORD_WIDTH] <= imem_rd_data;
                default: ;
            endcase
        end
    end

    assign inst           = inst_q;
    assign inst_addr      = inst_addr_q;
    assign inst_is_long   = inst_is_long_q;
    assign pc             = pc_q;
    assign fetch_complete = fetch_complete_q;

endmodule
